// File: rtl/sb_pkg.sv
// sb_pkg: shared sizing, types and constants for the valid scoreboard.
package sb_pkg;
  localparam int DEFAULT_NUM_PREGS = 64;
  localparam int DEFAULT_PREG_W = $clog2(DEFAULT_NUM_PREGS);
  typedef logic [DEFAULT_PREG_W-1:0] preg_t;
  localparam preg_t ZERO_PREG = '0;
endpackage

// File: rtl/valid_scoreboard_if.sv
// valid_scoreboard_if: dispatch/writeback/read bundle of the valid scoreboard.
// master drives flush, dispatch, writeback and source indices; slave returns
// rdy bits, busy_cnt_o and the sticky wb_err_o.
interface valid_scoreboard_if import sb_pkg::*; #(parameter int NUM_PREGS = DEFAULT_NUM_PREGS) ();
  localparam int PREG_W = $clog2(NUM_PREGS);
  logic flush_i;
  logic disp1_en_i, disp2_en_i, wb1_en_i, wb2_en_i;
  logic [PREG_W-1:0] disp1_preg_i, disp2_preg_i, wb1_preg_i, wb2_preg_i;
  logic [PREG_W-1:0] src11_preg_i, src12_preg_i, src21_preg_i, src22_preg_i;
  logic src11_rdy_o, src12_rdy_o, src21_rdy_o, src22_rdy_o;
  logic [PREG_W:0] busy_cnt_o;
  logic wb_err_o;
  modport master (
    output flush_i, disp1_en_i, disp2_en_i, wb1_en_i, wb2_en_i,
    output disp1_preg_i, disp2_preg_i, wb1_preg_i, wb2_preg_i,
    output src11_preg_i, src12_preg_i, src21_preg_i, src22_preg_i,
    input src11_rdy_o, src12_rdy_o, src21_rdy_o, src22_rdy_o, busy_cnt_o, wb_err_o
  );
  modport slave (
    input flush_i, disp1_en_i, disp2_en_i, wb1_en_i, wb2_en_i,
    input disp1_preg_i, disp2_preg_i, wb1_preg_i, wb2_preg_i,
    input src11_preg_i, src12_preg_i, src21_preg_i, src22_preg_i,
    output src11_rdy_o, src12_rdy_o, src21_rdy_o, src22_rdy_o, busy_cnt_o, wb_err_o
  );
endinterface

// File: rtl/sb_read_port.sv
// sb_read_port: one operand-ready lookup with optional writeback bypass and hazard mask.
// Ports: valid (stored table), src (queried preg), wb1/wb2 en+preg (bypass),
// haz_en/haz_preg (older-slot destination), rdy (result).
// Optional feature: VALID_SB_WB_BYPASS_EN makes same-cycle writebacks read as ready.
module sb_read_port import sb_pkg::*; #(
  parameter int NUM_PREGS = DEFAULT_NUM_PREGS,
  localparam int PREG_W = $clog2(NUM_PREGS)
) (
  input  logic [NUM_PREGS-1:0] valid,
  input  logic [PREG_W-1:0]    src,
  input  logic                 wb1_en,
  input  logic [PREG_W-1:0]    wb1_preg,
  input  logic                 wb2_en,
  input  logic [PREG_W-1:0]    wb2_preg,
  input  logic                 haz_en,
  input  logic [PREG_W-1:0]    haz_preg,
  output logic                 rdy
);
  logic byp;
`ifdef VALID_SB_WB_BYPASS_EN
  assign byp = (wb1_en && wb1_preg == src) || (wb2_en && wb2_preg == src);
`else
  logic unused_wb;
  assign byp = 1'b0;
  assign unused_wb = ^{wb1_en, wb1_preg, wb2_en, wb2_preg};
`endif
  // an older slot allocating this preg in the same bundle means the value is not produced yet
  assign rdy = (valid[src] | byp) & ~(haz_en && src != '0 && src == haz_preg);
endmodule

// File: rtl/valid_scoreboard.sv
// valid_scoreboard: physical-register ready table for the dual-issue core.
// Ports: clk, rst (sync, active-high), sb (valid_scoreboard_if.slave: flush,
// two dispatch clears, two writeback sets, four source-ready reads, busy count,
// sticky writeback error). Optional feature: VALID_SB_WB_BYPASS_EN (read bypass).
module valid_scoreboard import sb_pkg::*; #(
  parameter int NUM_PREGS = DEFAULT_NUM_PREGS
) (
  input logic clk,
  input logic rst,
  valid_scoreboard_if.slave sb
);
  localparam int PREG_W = $clog2(NUM_PREGS);
  localparam int CW = PREG_W + 1;
  logic [NUM_PREGS-1:0] valid, clr, set;
  logic [PREG_W:0] busy_cnt, busy_nxt;
  logic wb_err, err_hit;
  logic d1_fall, d2_fall, w1_rise, w2_rise;
  logic [PREG_W-1:0] d1, d2, w1, w2;
  assign d1 = sb.disp1_preg_i;
  assign d2 = sb.disp2_preg_i;
  assign w1 = sb.wb1_preg_i;
  assign w2 = sb.wb2_preg_i;
  // preg 0 is never cleared or set, so it stays hardwired valid
  always_comb begin
    clr = '0;
    set = '0;
    if (sb.disp1_en_i) clr[d1] = 1'b1;
    if (sb.disp2_en_i) clr[d2] = 1'b1;
    if (sb.wb1_en_i) set[w1] = 1'b1;
    if (sb.wb2_en_i) set[w2] = 1'b1;
    clr[0] = 1'b0;
    set[0] = 1'b0;
  end
  // duplicate targets are counted on the first port only; a clear cancels a set
  assign d1_fall = clr[d1] && sb.disp1_en_i && valid[d1];
  assign d2_fall = clr[d2] && sb.disp2_en_i && valid[d2] && !(sb.disp1_en_i && d1 == d2);
  assign w1_rise = set[w1] && sb.wb1_en_i && !clr[w1] && !valid[w1];
  assign w2_rise = set[w2] && sb.wb2_en_i && !clr[w2] && !valid[w2] && !(sb.wb1_en_i && w1 == w2);
  assign err_hit = (sb.wb1_en_i && set[w1] && valid[w1] && !clr[w1])
                || (sb.wb2_en_i && set[w2] && valid[w2] && !clr[w2]);
  assign busy_nxt = busy_cnt + CW'(d1_fall) + CW'(d2_fall) - CW'(w1_rise) - CW'(w2_rise);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '1;
      busy_cnt <= '0;
      wb_err <= 1'b0;
    end else if (sb.flush_i) begin
      valid <= '1;
      busy_cnt <= '0;
    end else begin
      valid <= (valid | set) & ~clr;
      busy_cnt <= busy_nxt;
      wb_err <= wb_err | err_hit;
    end
  end
  sb_read_port #(.NUM_PREGS(NUM_PREGS)) rp11 (
    .valid(valid), .src(sb.src11_preg_i), .wb1_en(sb.wb1_en_i), .wb1_preg(w1),
    .wb2_en(sb.wb2_en_i), .wb2_preg(w2), .haz_en(1'b0), .haz_preg(d1), .rdy(sb.src11_rdy_o)
  );
  sb_read_port #(.NUM_PREGS(NUM_PREGS)) rp12 (
    .valid(valid), .src(sb.src12_preg_i), .wb1_en(sb.wb1_en_i), .wb1_preg(w1),
    .wb2_en(sb.wb2_en_i), .wb2_preg(w2), .haz_en(1'b0), .haz_preg(d1), .rdy(sb.src12_rdy_o)
  );
  sb_read_port #(.NUM_PREGS(NUM_PREGS)) rp21 (
    .valid(valid), .src(sb.src21_preg_i), .wb1_en(sb.wb1_en_i), .wb1_preg(w1),
    .wb2_en(sb.wb2_en_i), .wb2_preg(w2), .haz_en(sb.disp1_en_i), .haz_preg(d1), .rdy(sb.src21_rdy_o)
  );
  sb_read_port #(.NUM_PREGS(NUM_PREGS)) rp22 (
    .valid(valid), .src(sb.src22_preg_i), .wb1_en(sb.wb1_en_i), .wb1_preg(w1),
    .wb2_en(sb.wb2_en_i), .wb2_preg(w2), .haz_en(sb.disp1_en_i), .haz_preg(d1), .rdy(sb.src22_rdy_o)
  );
  assign sb.busy_cnt_o = busy_cnt;
  assign sb.wb_err_o = wb_err;
endmodule

// File: tb/tb_valid_scoreboard.sv
// tb_valid_scoreboard: directed and randomized checks of valid_scoreboard against a set-based model.
module tb_valid_scoreboard;
  import sb_pkg::*;
  localparam int N = DEFAULT_NUM_PREGS;
  localparam int W = DEFAULT_PREG_W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  bit mv [N];
  bit merr;
  valid_scoreboard_if #(.NUM_PREGS(N)) sb ();
  valid_scoreboard #(.NUM_PREGS(N)) dut (.clk(clk), .rst(rst), .sb(sb));
  always #5 clk = ~clk;
  task automatic idle();
    sb.flush_i = 0;
    sb.disp1_en_i = 0;
    sb.disp2_en_i = 0;
    sb.wb1_en_i = 0;
    sb.wb2_en_i = 0;
  endtask
  task automatic srcs(input preg_t a, input preg_t b, input preg_t c, input preg_t d);
    sb.src11_preg_i = a;
    sb.src12_preg_i = b;
    sb.src21_preg_i = c;
    sb.src22_preg_i = d;
  endtask
  function automatic logic [3:0] got_rdy();
    return {sb.src11_rdy_o, sb.src12_rdy_o, sb.src21_rdy_o, sb.src22_rdy_o};
  endfunction
  // model: the table is a set of not-ready pregs; busy is simply its size
  function automatic void model_update();
    bit cleared [N];
    if (rst) begin
      foreach (mv[i]) mv[i] = 1;
      merr = 0;
    end else if (sb.flush_i) begin
      foreach (mv[i]) mv[i] = 1;
    end else begin
      foreach (cleared[i]) cleared[i] = 0;
      if (sb.disp1_en_i && sb.disp1_preg_i != 0) cleared[sb.disp1_preg_i] = 1;
      if (sb.disp2_en_i && sb.disp2_preg_i != 0) cleared[sb.disp2_preg_i] = 1;
      if (sb.wb1_en_i && sb.wb1_preg_i != 0 && !cleared[sb.wb1_preg_i] && mv[sb.wb1_preg_i]) merr = 1;
      if (sb.wb2_en_i && sb.wb2_preg_i != 0 && !cleared[sb.wb2_preg_i] && mv[sb.wb2_preg_i]) merr = 1;
      if (sb.wb1_en_i && sb.wb1_preg_i != 0) mv[sb.wb1_preg_i] = 1;
      if (sb.wb2_en_i && sb.wb2_preg_i != 0) mv[sb.wb2_preg_i] = 1;
      foreach (cleared[i]) if (cleared[i]) mv[i] = 0;
    end
  endfunction
  function automatic int model_busy();
    int n = 0;
    foreach (mv[i]) if (!mv[i]) n++;
    return n;
  endfunction
  function automatic bit exp_rdy(preg_t s, bit slot2);
    bit r = mv[s];
`ifdef VALID_SB_WB_BYPASS_EN
    if ((sb.wb1_en_i && sb.wb1_preg_i == s) || (sb.wb2_en_i && sb.wb2_preg_i == s)) r = 1;
`endif
    if (slot2 && sb.disp1_en_i && s != 0 && s == sb.disp1_preg_i) r = 0;
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    idle();
    srcs(0, 5, 63, 5);
    tick();
    rst = 0;
    #1;
    vectors++;
    if (got_rdy() !== 4'b1111) begin miscompares++; $display("FAIL reset_rdy got %b want 1111", got_rdy()); end
    vectors++;
    if (sb.busy_cnt_o !== '0) begin miscompares++; $display("FAIL reset_busy got %0d want 0", sb.busy_cnt_o); end
    vectors++;
    if (sb.wb_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", sb.wb_err_o); end
  endtask
  task automatic test_disp_wb();
    logic want_byp;
`ifdef VALID_SB_WB_BYPASS_EN
    want_byp = 1;
`else
    want_byp = 0;
`endif
    sb.disp1_en_i = 1; sb.disp1_preg_i = 5;
    sb.disp2_en_i = 1; sb.disp2_preg_i = 9;
    tick();
    idle();
    srcs(5, 9, 5, 9);
    #1;
    vectors++;
    if (got_rdy() !== 4'b0000) begin miscompares++; $display("FAIL disp_rdy got %b want 0000", got_rdy()); end
    vectors++;
    if (sb.busy_cnt_o !== 7'd2) begin miscompares++; $display("FAIL disp_busy got %0d want 2", sb.busy_cnt_o); end
    sb.wb1_en_i = 1; sb.wb1_preg_i = 5;
    #1;
    vectors++;
    if (sb.src11_rdy_o !== want_byp) begin miscompares++; $display("FAIL wb_bypass got %b want %b", sb.src11_rdy_o, want_byp); end
    tick();
    idle();
    #1;
    vectors++;
    if (got_rdy() !== 4'b1010) begin miscompares++; $display("FAIL wb_rdy got %b want 1010", got_rdy()); end
    vectors++;
    if (sb.busy_cnt_o !== 7'd1) begin miscompares++; $display("FAIL wb_busy got %0d want 1", sb.busy_cnt_o); end
    sb.wb2_en_i = 1; sb.wb2_preg_i = 9;
    tick();
    idle();
  endtask
  task automatic test_same_preg();
    sb.disp1_en_i = 1; sb.disp1_preg_i = 7;
    sb.disp2_en_i = 1; sb.disp2_preg_i = 7;
    tick();
    idle();
    #1;
    vectors++;
    if (sb.busy_cnt_o !== 7'd1) begin miscompares++; $display("FAIL dup_disp_busy got %0d want 1", sb.busy_cnt_o); end
    sb.wb1_en_i = 1; sb.wb1_preg_i = 7;
    sb.wb2_en_i = 1; sb.wb2_preg_i = 7;
    tick();
    idle();
    srcs(7, 0, 7, 63);
    #1;
    vectors++;
    if (sb.busy_cnt_o !== 7'd0) begin miscompares++; $display("FAIL dup_wb_busy got %0d want 0", sb.busy_cnt_o); end
    vectors++;
    if (got_rdy() !== 4'b1111) begin miscompares++; $display("FAIL dup_wb_rdy got %b want 1111", got_rdy()); end
    vectors++;
    if (sb.wb_err_o !== 1'b0) begin miscompares++; $display("FAIL dup_wb_err got %b want 0", sb.wb_err_o); end
  endtask
  task automatic test_hazard();
    sb.disp1_en_i = 1; sb.disp1_preg_i = 12;
    srcs(12, 3, 12, 12);
    #1;
    vectors++;
    if (got_rdy() !== 4'b1100) begin miscompares++; $display("FAIL hazard_rdy got %b want 1100", got_rdy()); end
    sb.disp1_preg_i = 0;
    srcs(0, 0, 0, 3);
    #1;
    vectors++;
    if (got_rdy() !== 4'b1111) begin miscompares++; $display("FAIL hazard_zero got %b want 1111", got_rdy()); end
    idle();
  endtask
  task automatic test_wb_err();
    sb.disp2_en_i = 1; sb.disp2_preg_i = 20;
    sb.wb1_en_i = 1; sb.wb1_preg_i = 20;
    tick();
    idle();
    srcs(20, 0, 0, 0);
    #1;
    vectors++;
    if (sb.src11_rdy_o !== 1'b0) begin miscompares++; $display("FAIL realloc_rdy got %b want 0", sb.src11_rdy_o); end
    vectors++;
    if (sb.wb_err_o !== 1'b0) begin miscompares++; $display("FAIL realloc_err got %b want 0", sb.wb_err_o); end
    sb.wb1_en_i = 1; sb.wb1_preg_i = 0;
    tick();
    idle();
    vectors++;
    if (sb.wb_err_o !== 1'b0) begin miscompares++; $display("FAIL zero_wb_err got %b want 0", sb.wb_err_o); end
    sb.wb1_en_i = 1; sb.wb1_preg_i = 30;
    tick();
    idle();
    vectors++;
    if (sb.wb_err_o !== 1'b1) begin miscompares++; $display("FAIL ready_wb_err got %b want 1", sb.wb_err_o); end
    sb.flush_i = 1;
    tick();
    idle();
    #1;
    vectors++;
    if ({sb.wb_err_o, sb.src11_rdy_o} !== 2'b11) begin miscompares++; $display("FAIL flush_err got %b want 11", {sb.wb_err_o, sb.src11_rdy_o}); end
  endtask
  task automatic test_flush();
    sb.disp1_en_i = 1; sb.disp1_preg_i = 40;
    sb.disp2_en_i = 1; sb.disp2_preg_i = 41;
    tick();
    idle();
    sb.disp1_en_i = 1; sb.disp1_preg_i = 42;
    tick();
    idle();
    #1;
    vectors++;
    if (sb.busy_cnt_o !== 7'd3) begin miscompares++; $display("FAIL preflush_busy got %0d want 3", sb.busy_cnt_o); end
    sb.flush_i = 1;
    sb.disp1_en_i = 1; sb.disp1_preg_i = 40;
    sb.wb1_en_i = 1; sb.wb1_preg_i = 41;
    tick();
    idle();
    srcs(40, 41, 42, 0);
    #1;
    vectors++;
    if (got_rdy() !== 4'b1111) begin miscompares++; $display("FAIL flush_rdy got %b want 1111", got_rdy()); end
    vectors++;
    if (sb.busy_cnt_o !== 7'd0) begin miscompares++; $display("FAIL flush_busy got %0d want 0", sb.busy_cnt_o); end
  endtask
  task automatic test_random();
    logic [3:0] want;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 24) == 0);
      sb.flush_i = ($urandom_range(0, 39) == 0);
      sb.disp1_en_i = $urandom_range(0, 1);
      sb.disp2_en_i = $urandom_range(0, 1);
      sb.wb1_en_i = $urandom_range(0, 1);
      sb.wb2_en_i = $urandom_range(0, 1);
      sb.disp1_preg_i = preg_t'($urandom_range(0, 15));
      sb.disp2_preg_i = preg_t'($urandom_range(0, 15));
      sb.wb1_preg_i = preg_t'($urandom_range(0, 15));
      sb.wb2_preg_i = preg_t'($urandom_range(0, 15));
      srcs(preg_t'($urandom_range(0, 15)), preg_t'($urandom_range(0, 15)),
           preg_t'($urandom_range(0, 15)), preg_t'($urandom_range(0, 15)));
      #1;
      want = {exp_rdy(sb.src11_preg_i, 0), exp_rdy(sb.src12_preg_i, 0),
              exp_rdy(sb.src21_preg_i, 1), exp_rdy(sb.src22_preg_i, 1)};
      vectors++;
      if (got_rdy() !== want) begin miscompares++; $display("FAIL rand_rdy cycle %0d got %b want %b", n, got_rdy(), want); end
      tick();
      vectors++;
      if (sb.busy_cnt_o !== (W+1)'(model_busy())) begin miscompares++; $display("FAIL rand_busy cycle %0d got %0d want %0d", n, sb.busy_cnt_o, model_busy()); end
      vectors++;
      if (sb.wb_err_o !== merr) begin miscompares++; $display("FAIL rand_err cycle %0d got %b want %b", n, sb.wb_err_o, merr); end
    end
    rst = 0;
    idle();
  endtask
  initial begin
    idle();
    srcs(0, 0, 0, 0);
    sb.disp1_preg_i = 0;
    sb.disp2_preg_i = 0;
    sb.wb1_preg_i = 0;
    sb.wb2_preg_i = 0;
    test_reset();
    test_disp_wb();
    test_same_preg();
    test_hazard();
    test_wb_err();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
